// File: rtl/muldiv_hilo_unit.sv
// Multicycle signed/unsigned multiply/divide engine with HI/LO result registers.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic               div_q;
    logic               neg_a;
    logic               neg_b;
    logic               dbz;
    logic [CW-1:0]      cnt;
    // Multiply: acc = running product, x_reg = shifted multiplicand, y_reg = multiplier.
    // Divide: acc[WIDTH:0] = partial remainder, x_reg low half = divisor, y_reg = dividend/quotient.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] x_reg;
    logic [WIDTH-1:0]   y_reg;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               sgn_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               rem_fits;
    logic [WIDTH:0]     rem_next;
    logic               last_iter;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        sgn_op   = ~op[0];
        abs_a    = (sgn_op && a[WIDTH-1]) ? -a : a;
        abs_b    = (sgn_op && b[WIDTH-1]) ? -b : b;
        mul_sum  = acc + (y_reg[0] ? x_reg : '0);
        rem_sh   = {acc[WIDTH-1:0], y_reg[WIDTH-1]};
        rem_fits = rem_sh >= {1'b0, x_reg[WIDTH-1:0]};
        rem_next = rem_fits ? (rem_sh - {1'b0, x_reg[WIDTH-1:0]}) : rem_sh;
`ifdef MULDIV_EARLY_OUT_EN
        last_iter = (cnt == CW'(1)) || (!div_q && ((y_reg >> 1) == '0));
`else
        last_iter = (cnt == CW'(1));
`endif
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix  = (neg_a ^ neg_b) ? -y_reg : y_reg;
        rem_fix  = neg_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            div_q <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            dbz   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            x_reg <= '0;
            y_reg <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (!busy) begin
                if (hi_wr) hi_q <= wr_data;
                if (lo_wr) lo_q <= wr_data;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        div_q <= op[1];
                        neg_a <= sgn_op & a[WIDTH-1];
                        neg_b <= sgn_op & b[WIDTH-1];
                        cnt   <= CW'(WIDTH);
                        acc   <= '0;
                        if (op[1]) begin
                            x_reg <= {{WIDTH{1'b0}}, abs_b};
                            y_reg <= abs_a;
                        end else begin
                            x_reg <= {{WIDTH{1'b0}}, abs_a};
                            y_reg <= abs_b;
                        end
                        dbz   <= op[1] && (b == '0);
                        state <= (op[1] && (b == '0)) ? S_DONE : S_CALC;
                    end else begin
                        dbz   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    cnt <= cnt - CW'(1);
                    if (!div_q) begin
                        acc   <= mul_sum;
                        x_reg <= x_reg << 1;
                        y_reg <= y_reg >> 1;
                    end else begin
                        acc   <= {{(WIDTH-1){1'b0}}, rem_next};
                        y_reg <= {y_reg[WIDTH-2:0], rem_fits};
                    end
                    if (last_iter) state <= S_FIXUP;
                end
                S_FIXUP: begin
                    if (!div_q) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state == S_CALC) || (state == S_FIXUP);
    assign done        = (state == S_DONE);
    assign div_by_zero = (state == S_DONE) && dbz;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
